imm_ext_pipe: RTL

Parametrised, registered immediate extender for the multi-cycle CPU datapath. It takes an IN_W-bit immediate field plus a mode code and produces an OUT_W-bit operand: sign-extended, zero-extended, upper-placed (LUI), or sign-extended branch offset shifted left by 2. The result is buffered behind a valid/ready handshake with a two-entry skid buffer, so the ID stage can stall without losing a decoded immediate. It sits between the instruction register and the ALU-B / PC-offset multiplexers.

---
 rtl/imm_ext_pkg.sv | 21 ++
 rtl/imm_ext_core.sv | 55 +++++
 rtl/imm_ext_pipe.sv | 121 ++++++++++++
 3 files changed

// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: types shared by the immediate extender slice.
//   - imm_mode_e  : extension mode code carried with each immediate
//   - buf_state_e : occupancy of the two-entry output skid buffer
package imm_ext_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    IMM_SIGN   = 2'b00,
    IMM_ZERO   = 2'b01,
    IMM_LUI    = 2'b10,
    IMM_BRANCH = 2'b11
  } imm_mode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } buf_state_e;

endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational immediate extension.
//   imm  [IN_W-1:0]   raw immediate field
//   mode [MODE_W-1:0] SIGN / ZERO / LUI / BRANCH
//   ext  [OUT_W-1:0]  extended operand
// Optional feature macro: IMM_EXT_BRANCH_EN. When undefined, BRANCH mode
// falls back to plain sign extension and no shifter is built.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]   imm,
  input  logic [MODE_W-1:0] mode,
  output logic [OUT_W-1:0]  ext
);

  // The branch form drops two MSBs of the sign-extended value, so at least
  // two guard bits above the immediate are required.
  generate
    if (OUT_W < IN_W + 2) begin : g_bad_width
      $error("imm_ext_core: OUT_W must be at least IN_W+2");
    end
  endgenerate

  logic [OUT_W-1:0] sign_ext_s;
  logic [OUT_W-1:0] zero_ext_s;
  logic [OUT_W-1:0] lui_ext_s;

  assign sign_ext_s = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
  assign zero_ext_s = {{(OUT_W-IN_W){1'b0}}, imm};
  assign lui_ext_s  = {imm, {(OUT_W-IN_W){1'b0}}};

`ifdef IMM_EXT_BRANCH_EN
  logic [OUT_W-1:0] branch_ext_s;
  assign branch_ext_s = {sign_ext_s[OUT_W-3:0], 2'b00};
`endif

  // Select the extension form for the current mode.
  always_comb begin
    ext = sign_ext_s;
    case (mode)
      IMM_SIGN:   ext = sign_ext_s;
      IMM_ZERO:   ext = zero_ext_s;
      IMM_LUI:    ext = lui_ext_s;
`ifdef IMM_EXT_BRANCH_EN
      IMM_BRANCH: ext = branch_ext_s;
`else
      IMM_BRANCH: ext = sign_ext_s;
`endif
      default:    ext = sign_ext_s;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate extender with a two-entry skid buffer.
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   producer handshake (in_ready is registered)
//   in_imm, in_mode     immediate field and extension mode
//   out_valid/out_ready consumer handshake
//   out_data            extended immediate, straight from the main register
// Optional feature macro: IMM_EXT_BRANCH_EN (see imm_ext_core).
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_imm,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data
);

  logic [OUT_W-1:0] ext_s;
  logic             accept_s;
  logic             drain_s;

  buf_state_e       state_r,      state_nxt_s;
  logic [OUT_W-1:0] main_r,       main_nxt_s;
  logic [OUT_W-1:0] skid_r,       skid_nxt_s;
  logic             main_valid_r, main_valid_nxt_s;
  logic             skid_valid_r, skid_valid_nxt_s;
  logic             in_ready_r;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm  (in_imm),
    .mode (in_mode),
    .ext  (ext_s)
  );

  assign accept_s  = in_valid & in_ready_r;
  assign drain_s   = main_valid_r & out_ready;
  assign in_ready  = in_ready_r;
  assign out_valid = main_valid_r;
  assign out_data  = main_r;

  // Buffer occupancy FSM: decide where the new result goes and what drains.
  always_comb begin
    state_nxt_s      = state_r;
    main_nxt_s       = main_r;
    skid_nxt_s       = skid_r;
    main_valid_nxt_s = main_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          main_nxt_s       = ext_s;
          main_valid_nxt_s = 1'b1;
          state_nxt_s      = ONE;
        end else begin
          state_nxt_s      = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && drain_s) begin
          // Consumer takes the old value this cycle; replace it without a bubble.
          main_nxt_s       = ext_s;
          state_nxt_s      = ONE;
        end else if (accept_s) begin
          skid_nxt_s       = ext_s;
          skid_valid_nxt_s = 1'b1;
          state_nxt_s      = TWO;
        end else if (drain_s) begin
          main_valid_nxt_s = 1'b0;
          state_nxt_s      = EMPTY;
        end else begin
          state_nxt_s      = ONE;
        end
      end
      TWO: begin
        // in_ready is low here, so only a drain can happen.
        if (drain_s) begin
          main_nxt_s       = skid_r;
          skid_valid_nxt_s = 1'b0;
          state_nxt_s      = ONE;
        end else begin
          state_nxt_s      = TWO;
        end
      end
      default: begin
        main_valid_nxt_s = 1'b0;
        skid_valid_nxt_s = 1'b0;
        state_nxt_s      = EMPTY;
      end
    endcase
  end

  // State and data registers; in_ready is the registered inverse of skid valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= EMPTY;
      main_r       <= {OUT_W{1'b0}};
      skid_r       <= {OUT_W{1'b0}};
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      state_r      <= state_nxt_s;
      main_r       <= main_nxt_s;
      skid_r       <= skid_nxt_s;
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      in_ready_r   <= ~skid_valid_nxt_s;
    end
  end

endmodule
